// File: rtl/seg_scan_driver_if.sv
// Segment-buffer-to-display bus for seg_scan_driver.
// With SEG_SCAN_BLINK_EN defined the bus also carries the per-digit blink select.
`default_nettype none

interface seg_scan_driver_if;

    localparam int unsigned DIGITS  = 8;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned FRAME_W = DIGITS * SEG_W;
    localparam int unsigned IDX_W   = 3;

    logic               en;
    logic [FRAME_W-1:0] frame_in;
`ifdef SEG_SCAN_BLINK_EN
    logic [DIGITS-1:0]  blink_mask;
`endif
    logic [SEG_W-1:0]   seg_n;
    logic [DIGITS-1:0]  an_n;
    logic [IDX_W-1:0]   digit_idx;
    logic               frame_done;

    // Source of the segment buffer and observer of the display pins
    modport master (
        output en,
        output frame_in,
`ifdef SEG_SCAN_BLINK_EN
        output blink_mask,
`endif
        input  seg_n,
        input  an_n,
        input  digit_idx,
        input  frame_done
    );

    // The scanner itself
    modport slave (
        input  en,
        input  frame_in,
`ifdef SEG_SCAN_BLINK_EN
        input  blink_mask,
`endif
        output seg_n,
        output an_n,
        output digit_idx,
        output frame_done
    );

endinterface

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scanner for an 8-digit common-anode
// seven-segment display. Each digit slot is SCAN_DIV cycles: BLANK_CYCLES
// with every anode off, then the digit shown. The 64-bit buffer is captured
// once per frame so mid-frame writes never tear the image.
// Optional feature macro: SEG_SCAN_BLINK_EN (per-digit blinking via blink_mask,
// toggling every BLINK_FRAMES frames).
`default_nettype none

module seg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic clk,
    input  logic rst,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
    localparam int unsigned DIGITS  = 8;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned FRAME_W = DIGITS * SEG_W;
    localparam int unsigned IDX_W   = 3;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam bit               HAS_BLANK  = (BLANK_CYCLES != 0);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DIGITS - 1);
    localparam logic [SEG_W-1:0] SEG_OFF    = '1;
    localparam logic [DIGITS-1:0] AN_OFF    = '1;

    // Reject illegal parameterisations at elaboration
    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20) || BLANK_CYCLES >= SCAN_DIV || BLINK_FRAMES < 1)
    begin : g_bad_params
        $error("seg_scan_driver: illegal SCAN_DIV/BLANK_CYCLES/BLINK_FRAMES");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] snapshot;

    // Per-digit "hide now" masks: for the current frame and for the frame about to start
    logic [DIGITS-1:0]  mask_cur;
    logic [DIGITS-1:0]  mask_wrap;

    logic               slot_end;
    logic               frame_wrap;
    state_t             entry_state;
    logic [IDX_W-1:0]   entry_digit;
    logic [FRAME_W-1:0] entry_img;
    logic [DIGITS-1:0]  entry_mask;
    logic [SEG_W-1:0]   entry_seg;
    logic [DIGITS-1:0]  entry_an;
    logic [SEG_W-1:0]   show_seg;
    logic [DIGITS-1:0]  show_an;

    function automatic logic [SEG_W-1:0] digit_byte(input logic [FRAME_W-1:0] img,
                                                     input logic [IDX_W-1:0]   d);
        return img[{d, 3'b000} +: SEG_W];
    endfunction

    function automatic logic [DIGITS-1:0] anode_code(input logic [IDX_W-1:0] d);
        return ~(DIGITS'(1) << d);
    endfunction

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned       FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FLAST  = FCNT_W'(BLINK_FRAMES - 1);

    logic              hide;
    logic [FCNT_W-1:0] fcnt;
    logic              hide_wrap;

    // Blink phase as it will be once the current frame wraps
    always_comb begin
        hide_wrap = (fcnt == FLAST) ? ~hide : hide;
        mask_cur  = hide      ? bus.blink_mask : '0;
        mask_wrap = hide_wrap ? bus.blink_mask : '0;
    end

    // Frame counter and blink phase; visible phase after reset or en low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hide <= 1'b0;
            fcnt <= '0;
        end else if (!bus.en) begin
            hide <= 1'b0;
            fcnt <= '0;
        end else if (frame_wrap) begin
            if (fcnt == FLAST) begin
                fcnt <= '0;
                hide <= ~hide;
            end else begin
                fcnt <= fcnt + FCNT_W'(1);
            end
        end
    end
`else
    // Blinking compiled out: nothing is ever hidden
    always_comb begin
        mask_cur  = '0;
        mask_wrap = '0;
    end
`endif

    // Slot boundaries and the drive values for the slot about to be entered
    always_comb begin
        slot_end    = (state == SHOW) && (cnt == SLOT_LAST);
        frame_wrap  = slot_end && (bus.digit_idx == LAST_DIGIT) && bus.en;
        entry_state = HAS_BLANK ? BLANK : SHOW;
        entry_digit = (state == IDLE) ? '0 : IDX_W'(bus.digit_idx + IDX_W'(1));
        entry_img   = ((state == IDLE) || frame_wrap) ? bus.frame_in : snapshot;
        entry_mask  = frame_wrap ? mask_wrap : mask_cur;
        if (HAS_BLANK) begin
            entry_an  = AN_OFF;
            entry_seg = SEG_OFF;
        end else begin
            entry_an  = anode_code(entry_digit);
            entry_seg = digit_byte(entry_img, entry_digit) | {SEG_W{entry_mask[entry_digit]}};
        end
        show_an  = anode_code(bus.digit_idx);
        show_seg = digit_byte(snapshot, bus.digit_idx) | {SEG_W{mask_cur[bus.digit_idx]}};
    end

    // Scan FSM with registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            snapshot       <= '1;
            bus.seg_n      <= SEG_OFF;
            bus.an_n       <= AN_OFF;
            bus.digit_idx  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            if (!bus.en) begin
                state         <= IDLE;
                cnt           <= '0;
                bus.digit_idx <= '0;
                bus.seg_n     <= SEG_OFF;
                bus.an_n      <= AN_OFF;
            end else begin
                case (state)
                    IDLE: begin
                        state         <= entry_state;
                        cnt           <= '0;
                        bus.digit_idx <= '0;
                        snapshot      <= bus.frame_in;
                        bus.seg_n     <= entry_seg;
                        bus.an_n      <= entry_an;
                    end
                    BLANK: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == BLANK_LAST) begin
                            state     <= SHOW;
                            bus.an_n  <= show_an;
                            bus.seg_n <= show_seg;
                        end
                    end
                    SHOW: begin
                        if (slot_end) begin
                            cnt           <= '0;
                            state         <= entry_state;
                            bus.digit_idx <= entry_digit;
                            bus.seg_n     <= entry_seg;
                            bus.an_n      <= entry_an;
                            if (frame_wrap) begin
                                snapshot       <= bus.frame_in;
                                bus.frame_done <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        bus.seg_n <= SEG_OFF;
                        bus.an_n  <= AN_OFF;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances (BLANK_CYCLES=2 and 0,
// SCAN_DIV=8) share the same stimulus. A time-based reference model pushes the
// expected pins for every cycle; a monitor pops and compares on the falling edge.
`timescale 1ns/1ps

module tb_seg_scan_driver;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLK_A = 2;
    localparam int unsigned BLK_B = 0;
    localparam int unsigned FRAME = 8 * DIV;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] an;
        logic [2:0] idx;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_scan_driver_if ifa();
    seg_scan_driver_if ifb();

    seg_scan_driver #(.SCAN_DIV(DIV), .BLANK_CYCLES(BLK_A), .BLINK_FRAMES(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    seg_scan_driver #(.SCAN_DIV(DIV), .BLANK_CYCLES(BLK_B), .BLINK_FRAMES(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    exp_t qa[$];
    exp_t qb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Expected pins t cycles into a running frame whose captured image is img
    function automatic exp_t model_out(input int unsigned blank, input bit active,
                                       input int unsigned t, input logic [63:0] img,
                                       input bit fd);
        exp_t e;
        int unsigned d;
        int unsigned pos;
        e = '{seg: 8'hFF, an: 8'hFF, idx: 3'd0, fd: 1'b0};
        if (active) begin
            d     = t / DIV;
            pos   = t % DIV;
            e.idx = 3'(d);
            e.fd  = fd;
            if (pos >= blank) begin
                e.an  = 8'hFF ^ (8'h01 << d);
                e.seg = img[8*d +: 8];
            end
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic check_pins(input string tag, input exp_t e, input logic [7:0] seg,
                              input logic [7:0] an, input logic [2:0] idx, input logic fd);
        cmp({tag, ".seg_n"}, seg, e.seg);
        cmp({tag, ".an_n"}, an, e.an);
        cmp({tag, ".digit_idx"}, 8'(idx), 8'(e.idx));
        cmp({tag, ".frame_done"}, 8'(fd), 8'(e.fd));
    endtask

    task automatic set_inputs(input logic e, input logic [63:0] f);
        ifa.en       = e;
        ifb.en       = e;
        ifa.frame_in = f;
        ifb.frame_in = f;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference model: elapsed time since start decides digit and blank/show
    initial begin : model
        bit          running;
        int unsigned t;
        logic [63:0] snap;
        bit          fd;
        running = 1'b0;
        t       = 0;
        snap    = '1;
        forever begin
            @(posedge clk);
            fd = 1'b0;
            if (rst || !ifa.en) begin
                running = 1'b0;
            end else if (!running) begin
                running = 1'b1;
                t       = 0;
                snap    = ifa.frame_in;
            end else begin
                t++;
                if (t == FRAME) begin
                    t    = 0;
                    snap = ifa.frame_in;
                    fd   = 1'b1;
                end
            end
            qa.push_back(model_out(BLK_A, running, t, snap, fd));
            qb.push_back(model_out(BLK_B, running, t, snap, fd));
        end
    end

    // Monitor: every cycle presents an output; compare against the scoreboard
    initial begin : monitor
        exp_t ea;
        exp_t eb;
        forever begin
            @(negedge clk);
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                check_pins("a", ea, ifa.seg_n, ifa.an_n, ifa.digit_idx, ifa.frame_done);
                check_pins("b", eb, ifb.seg_n, ifb.an_n, ifb.digit_idx, ifb.frame_done);
            end
        end
    end

    // Stimulus
    initial begin : stim
        exp_t rst_exp;
        rst_exp = '{seg: 8'hFF, an: 8'hFF, idx: 3'd0, fd: 1'b0};
        rst = 1'b1;
        set_inputs(1'b0, 64'h0);
`ifdef SEG_SCAN_BLINK_EN
        ifa.blink_mask = 8'h00;
        ifb.blink_mask = 8'h00;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Known image; mid-frame buffer change must stay invisible until the wrap
        set_inputs(1'b1, 64'h0123_4567_89AB_CDEF);
        repeat (21) @(negedge clk);
        set_inputs(1'b1, 64'h0);
        repeat (2 * FRAME) @(negedge clk);

        // Drop en mid-frame, then restart with a fresh image
        set_inputs(1'b0, rand64());
        repeat (3) @(negedge clk);
        set_inputs(1'b1, rand64());
        repeat (FRAME + 30) @(negedge clk);
        set_inputs(1'b0, ifa.frame_in);
        repeat (2) @(negedge clk);

        // Randomized buffer traffic with occasional enable drops
        set_inputs(1'b1, rand64());
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(7, 0) == 0)
                set_inputs(ifa.en, rand64());
            if ($urandom_range(199, 0) == 0) begin
                set_inputs(1'b0, ifa.frame_in);
                repeat ($urandom_range(3, 1)) @(negedge clk);
                set_inputs(1'b1, rand64());
            end
        end

        // Asynchronous reset in the middle of a SHOW period
        set_inputs(1'b0, ifa.frame_in);
        repeat (2) @(negedge clk);
        set_inputs(1'b1, rand64());
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_pins("a_async_rst", rst_exp, ifa.seg_n, ifa.an_n, ifa.digit_idx, ifa.frame_done);
        check_pins("b_async_rst", rst_exp, ifb.seg_n, ifb.an_n, ifb.digit_idx, ifb.frame_done);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 10) @(negedge clk);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
